// File: rtl/llc_mem_flush_walker_pkg.sv
// Shared constants and types for the LLC local-memory flush walker.
// Holds the cache geometry, the INVALID state encoding, the set/way/line
// types used on the localmem and writeback ports, and the walker state enum.
package llc_mem_flush_walker_pkg;

  localparam int SETS         = 512;
  localparam int WAYS         = 16;
  localparam int TAG_BITS     = 15;
  localparam int STATE_BITS   = 3;
  localparam int LINE_BITS    = 128;
  localparam int SHARERS_BITS = 16;
  localparam int SET_BITS     = $clog2(SETS);
  localparam int WAY_BITS     = $clog2(WAYS);

  typedef logic [SET_BITS-1:0]          llc_set_t;
  typedef logic [WAY_BITS-1:0]          llc_way_t;
  typedef logic [TAG_BITS-1:0]          llc_tag_t;
  typedef logic [STATE_BITS-1:0]        llc_state_t;
  typedef logic [LINE_BITS-1:0]         line_t;
  typedef logic [SHARERS_BITS-1:0]      sharers_t;
  typedef logic [WAYS-1:0]              way_mask_t;
  typedef logic [TAG_BITS+SET_BITS-1:0] line_addr_t;

  localparam llc_state_t INVALID  = '0;
  localparam llc_set_t   LAST_SET = llc_set_t'(SETS - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_SCAN,
    ST_INV
  } walk_state_t;

endpackage

// File: rtl/llc_lowest_bit_enc.sv
// Lowest-set-bit encoder over a per-way mask.
// Ports: mask (WAYS-bit way mask in), idx (index of lowest set bit, 0 when
// mask is empty), any (high when at least one bit is set).
module llc_lowest_bit_enc
  import llc_mem_flush_walker_pkg::*;
(
  input  way_mask_t mask,
  output llc_way_t  idx,
  output logic      any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = llc_way_t'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/llc_mem_flush_walker.sv
// LLC local-memory walker: invalidates every set after reset, and on a flush
// request reads each set, writes back each valid+dirty way over a
// valid/ready port, then invalidates the set.
// Ports: clk/rst (async active-low); flush_req_valid/ready handshake,
// flush_done pulse, busy; localmem control (mem_rd_en, mem_set,
// mem_wr_rst_flush, mem_wr_data_*) and read data (rd_data_*[WAYS]);
// writeback port (wb_valid, wb_ready, wb_addr, wb_line).
//
// state | meaning
// INIT  | post-reset invalidate walk, one set per cycle
// IDLE  | waiting for a flush request
// RD    | read of set_cnt issued
// WAIT  | read data valid, dirty mask captured
// SCAN  | writing back dirty ways, lowest index first
// INV   | invalidate set_cnt, then next set or done
module llc_mem_flush_walker
  import llc_mem_flush_walker_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_req_valid,
  output logic       flush_req_ready,
  output logic       flush_done,
  output logic       busy,
  output logic       mem_rd_en,
  output llc_set_t   mem_set,
  output way_mask_t  mem_wr_rst_flush,
  output llc_state_t mem_wr_data_state,
  output logic       mem_wr_data_dirty,
  output sharers_t   mem_wr_data_sharers,
  input  llc_state_t rd_data_state [WAYS],
  input  logic       rd_data_dirty [WAYS],
  input  llc_tag_t   rd_data_tag   [WAYS],
  input  line_t      rd_data_line  [WAYS],
  output logic       wb_valid,
  input  logic       wb_ready,
  output line_addr_t wb_addr,
  output line_t      wb_line
);

  walk_state_t state_q, state_d;
  llc_set_t    set_cnt_q, set_cnt_d;
  way_mask_t   dmask_q, dmask_d;
  way_mask_t   rd_dmask;
  llc_way_t    scan_way;
  logic        scan_any;

  logic       mem_rd_en_q, mem_rd_en_d;
  llc_set_t   mem_set_q, mem_set_d;
  way_mask_t  mem_wr_q, mem_wr_d;
  logic       wb_valid_q, wb_valid_d;
  line_addr_t wb_addr_q, wb_addr_d;
  line_t      wb_line_q, wb_line_d;
  logic       flush_done_q, flush_done_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;

  llc_lowest_bit_enc u_enc (
    .mask (dmask_q),
    .idx  (scan_way),
    .any  (scan_any)
  );

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rd_dmask[w] = (rd_data_state[w] != INVALID) & rd_data_dirty[w];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      set_cnt_q    <= '0;
      dmask_q      <= '0;
      mem_rd_en_q  <= 1'b0;
      mem_set_q    <= '0;
      mem_wr_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_line_q    <= '0;
      flush_done_q <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      set_cnt_q    <= set_cnt_d;
      dmask_q      <= dmask_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_set_q    <= mem_set_d;
      mem_wr_q     <= mem_wr_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_line_q    <= wb_line_d;
      flush_done_q <= flush_done_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    dmask_d   = dmask_q;
    case (state_q)
      ST_INIT: begin
        set_cnt_d = set_cnt_q + 1'b1;
        if (set_cnt_q == LAST_SET) begin
          state_d   = ST_IDLE;
          set_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        if (flush_req_valid && ready_q) begin
          state_d   = ST_RD;
          set_cnt_d = '0;
        end
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: begin
        dmask_d = rd_dmask;
        state_d = (rd_dmask == '0) ? ST_INV : ST_SCAN;
      end
      ST_SCAN: begin
        // dmask_q is frozen while wb_valid is up, so scan_way is still the
        // way being handed off.
        if (wb_valid_q && wb_ready) begin
          dmask_d = dmask_q & ~(way_mask_t'(1) << scan_way);
          if (dmask_d == '0) state_d = ST_INV;
        end else if (!scan_any) begin
          state_d = ST_INV;
        end
      end
      ST_INV: begin
        if (set_cnt_q == LAST_SET) begin
          state_d = ST_IDLE;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
          state_d   = ST_RD;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Registered outputs are computed from the next state so they line up
  // with state_q. INIT is the exception: it streams one write per cycle
  // from set_cnt_q, so the last INIT write lands in the first IDLE cycle.
  always_comb begin
    mem_rd_en_d  = 1'b0;
    mem_wr_d     = '0;
    mem_set_d    = mem_set_q;
    wb_valid_d   = wb_valid_q;
    wb_addr_d    = wb_addr_q;
    wb_line_d    = wb_line_q;
    flush_done_d = (state_q == ST_INV) && (set_cnt_q == LAST_SET);
    ready_d      = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    if (state_q == ST_INIT) begin
      mem_rd_en_d = 1'b1;
      mem_wr_d    = '1;
      mem_set_d   = set_cnt_q;
    end else begin
      case (state_d)
        ST_RD: begin
          mem_rd_en_d = 1'b1;
          mem_set_d   = set_cnt_d;
        end
        ST_INV: begin
          mem_rd_en_d = 1'b1;
          mem_wr_d    = '1;
          mem_set_d   = set_cnt_d;
        end
        default: ;
      endcase
    end
    if (state_q == ST_SCAN) begin
      if (!wb_valid_q && scan_any) begin
        wb_valid_d = 1'b1;
        wb_addr_d  = {rd_data_tag[scan_way], set_cnt_q};
        wb_line_d  = rd_data_line[scan_way];
      end else if (wb_valid_q && wb_ready) begin
        wb_valid_d = 1'b0;
      end
    end
  end

  assign flush_req_ready     = ready_q;
  assign flush_done          = flush_done_q;
  assign busy                = busy_q;
  assign mem_rd_en           = mem_rd_en_q;
  assign mem_set             = mem_set_q;
  assign mem_wr_rst_flush    = mem_wr_q;
  assign mem_wr_data_state   = INVALID;
  assign mem_wr_data_dirty   = 1'b0;
  assign mem_wr_data_sharers = '0;
  assign wb_valid            = wb_valid_q;
  assign wb_addr             = wb_addr_q;
  assign wb_line             = wb_line_q;

endmodule

// File: tb/tb_llc_mem_flush_walker.sv
// Self-checking bench for llc_mem_flush_walker: a behavioural localmem model
// with 1-cycle read latency, a writeback scoreboard filled from the model
// contents when a flush starts, and one task per scenario.
module tb_llc_mem_flush_walker;
  import llc_mem_flush_walker_pkg::*;

  logic       clk, rst, flush_req_valid, flush_req_ready, flush_done, busy;
  logic       mem_rd_en, mem_wr_data_dirty, wb_valid, wb_ready;
  llc_set_t   mem_set;
  way_mask_t  mem_wr_rst_flush;
  llc_state_t mem_wr_data_state;
  sharers_t   mem_wr_data_sharers;
  llc_state_t q_state [WAYS];
  logic       q_dirty [WAYS];
  llc_tag_t   q_tag   [WAYS];
  line_t      q_line  [WAYS];
  line_addr_t wb_addr;
  line_t      wb_line;

  llc_state_t m_state [SETS][WAYS];
  logic       m_dirty [SETS][WAYS];

  typedef struct packed { line_addr_t addr; line_t line; } wb_t;
  wb_t sb[$];
  wb_t mon_exp;

  int chk_cnt = 0, pass_cnt = 0, done_cnt = 0, hs_cnt = 0;

  llc_mem_flush_walker dut (
    .clk(clk), .rst(rst), .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready),
    .flush_done(flush_done), .busy(busy), .mem_rd_en(mem_rd_en), .mem_set(mem_set),
    .mem_wr_rst_flush(mem_wr_rst_flush), .mem_wr_data_state(mem_wr_data_state),
    .mem_wr_data_dirty(mem_wr_data_dirty), .mem_wr_data_sharers(mem_wr_data_sharers),
    .rd_data_state(q_state), .rd_data_dirty(q_dirty), .rd_data_tag(q_tag), .rd_data_line(q_line),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_line(wb_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic llc_tag_t tag_of(int s, int w);
    return llc_tag_t'({w[3:0], s[8:0], 2'b01});
  endfunction

  function automatic line_t line_of(int s, int w);
    return {s[15:0], w[15:0], 96'h0123_4567_89AB_CDEF_FEDC_BA98};
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en === 1'b1) begin
      if (mem_wr_rst_flush != '0) begin
        for (int w = 0; w < WAYS; w++)
          if (mem_wr_rst_flush[w]) begin
            m_state[mem_set][w] = INVALID;
            m_dirty[mem_set][w] = 1'b0;
          end
      end else begin
        for (int w = 0; w < WAYS; w++) begin
          q_state[w] <= m_state[mem_set][w];
          q_dirty[w] <= m_dirty[mem_set][w];
          q_tag[w]   <= tag_of(int'(mem_set), w);
          q_line[w]  <= line_of(int'(mem_set), w);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (flush_done === 1'b1) done_cnt++;
      if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
        hs_cnt++;
        chk_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL wb_unexpected: got addr %h, want no writeback", wb_addr);
        end else begin
          mon_exp = sb.pop_front();
          if (wb_addr !== mon_exp.addr || wb_line !== mon_exp.line)
            $display("FAIL wb_match: got addr %h line %h, want addr %h line %h",
                     wb_addr, wb_line, mon_exp.addr, mon_exp.line);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic start_flush(output bit accepted);
    wb_t e;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_state[s][w] != INVALID && m_dirty[s][w] === 1'b1) begin
          e.addr = {tag_of(s, w), llc_set_t'(s)};
          e.line = line_of(s, w);
          sb.push_back(e);
        end
    @(posedge clk); #1;
    flush_req_valid = 1'b1;
    accepted = 1'b0;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      accepted = flush_req_ready;
      @(posedge clk); #1;
    end
    flush_req_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output int inv_cnt, output int wbv, output int last_set,
                           output bit prev_inv, output bit got, output logic busy_at_done);
    bit cur_inv;
    cycles = 0; inv_cnt = 0; wbv = 0; last_set = -1; prev_inv = 0; got = 0; busy_at_done = 1'bx;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (flush_done === 1'b1) begin got = 1; busy_at_done = busy; break; end
      cycles++;
      cur_inv = (mem_rd_en === 1'b1 && mem_wr_rst_flush === '1);
      if (cur_inv) begin inv_cnt++; last_set = int'(mem_set); end
      if (wb_valid === 1'b1) wbv++;
      prev_inv = cur_inv;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk_cnt++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); else pass_cnt++;
    chk_cnt++; if (mem_wr_rst_flush !== '0) $display("FAIL reset_wr: got %h want 0", mem_wr_rst_flush); else pass_cnt++;
    chk_cnt++; if (mem_set !== '0) $display("FAIL reset_set: got %0d want 0", mem_set); else pass_cnt++;
    chk_cnt++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b want 0", wb_valid); else pass_cnt++;
    chk_cnt++; if (flush_done !== 1'b0) $display("FAIL reset_done: got %b want 0", flush_done); else pass_cnt++;
    chk_cnt++; if (flush_req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", flush_req_ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else pass_cnt++;
    chk_cnt++;
    if (mem_wr_data_state !== '0 || mem_wr_data_dirty !== 1'b0 || mem_wr_data_sharers !== '0)
      $display("FAIL reset_wr_data: got %0d/%b/%h want 0/0/0", mem_wr_data_state, mem_wr_data_dirty, mem_wr_data_sharers);
    else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_init();
    int n = 0, bad = 0;
    bit seen_end = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (mem_rd_en === 1'b1 && mem_wr_rst_flush === '1) begin
        if (mem_set !== llc_set_t'(n)) bad++;
        n++;
      end else if (n > 0) begin
        seen_end = 1;
        break;
      end
    end
    chk_cnt++; if (n != SETS) $display("FAIL init_len: got %0d cycles want %0d", n, SETS); else pass_cnt++;
    chk_cnt++; if (bad != 0) $display("FAIL init_set_order: got %0d out-of-order sets want 0", bad); else pass_cnt++;
    chk_cnt++; if (!seen_end || flush_req_ready !== 1'b1) $display("FAIL init_ready: got %b want 1", flush_req_ready); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL init_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_clean_flush();
    bit acc, prev_inv, got;
    int cyc, inv, wbv, last;
    logic bad;
    start_flush(acc);
    chk_cnt++; if (!acc) $display("FAIL clean_accept: got 0 want 1"); else pass_cnt++;
    wait_done(cyc, inv, wbv, last, prev_inv, got, bad);
    chk_cnt++; if (!got || cyc != 3 * SETS) $display("FAIL clean_cycles: got %0d (done %b) want %0d", cyc, got, 3 * SETS); else pass_cnt++;
    chk_cnt++; if (inv != SETS) $display("FAIL clean_inv_count: got %0d want %0d", inv, SETS); else pass_cnt++;
    chk_cnt++; if (wbv != 0) $display("FAIL clean_wb_valid: got %0d cycles want 0", wbv); else pass_cnt++;
    chk_cnt++; if (!prev_inv || last != SETS - 1) $display("FAIL clean_done_timing: got last inv %0d prev %b want %0d 1", last, prev_inv, SETS - 1); else pass_cnt++;
    chk_cnt++; if (bad !== 1'b0) $display("FAIL clean_busy_at_done: got %b want 0", bad); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (flush_done !== 1'b0) $display("FAIL clean_done_pulse: got %b want 0", flush_done); else pass_cnt++;
  endtask

  task automatic test_dirty_ways();
    bit acc, prev_inv, got;
    int cyc, inv, wbv, last, hs0, left;
    logic bd;
    m_state[5][2] = 3'd2; m_dirty[5][2] = 1'b1;
    m_state[5][9] = 3'd5; m_dirty[5][9] = 1'b1;
    m_state[5][3] = INVALID; m_dirty[5][3] = 1'b1;
    m_state[5][7] = 3'd1; m_dirty[5][7] = 1'b0;
    m_state[SETS-1][WAYS-1] = 3'd7; m_dirty[SETS-1][WAYS-1] = 1'b1;
    wb_ready = 1'b1;
    hs0 = hs_cnt;
    start_flush(acc);
    chk_cnt++; if (sb.size() != 3) $display("FAIL dirty_expected: got %0d queued want 3", sb.size()); else pass_cnt++;
    wait_done(cyc, inv, wbv, last, prev_inv, got, bd);
    chk_cnt++; if (!got || cyc != 3 * SETS + 6) $display("FAIL dirty_cycles: got %0d want %0d", cyc, 3 * SETS + 6); else pass_cnt++;
    chk_cnt++; if (hs_cnt - hs0 != 3 || sb.size() != 0) $display("FAIL dirty_wb_count: got %0d left %0d want 3 0", hs_cnt - hs0, sb.size()); else pass_cnt++;
    left = 0;
    for (int w = 0; w < WAYS; w++) if (m_state[5][w] != INVALID || m_dirty[5][w] !== 1'b0) left++;
    chk_cnt++; if (left != 0) $display("FAIL dirty_set5_inv: got %0d ways left want 0", left); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit acc, prev_inv, got, found;
    int cyc, inv, wbv, last, bad;
    logic bd;
    line_addr_t a0;
    line_t l0;
    llc_set_t s0;
    m_state[7][4] = 3'd6; m_dirty[7][4] = 1'b1;
    wb_ready = 1'b0;
    start_flush(acc);
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin found = 1; break; end
    end
    a0 = wb_addr; l0 = wb_line; s0 = mem_set; bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wb_valid !== 1'b1 || wb_addr !== a0 || wb_line !== l0 || mem_rd_en !== 1'b0 || mem_set !== s0) bad++;
    end
    chk_cnt++; if (!found || bad != 0) $display("FAIL bp_stable: got %0d unstable cycles (found %b) want 0", bad, found); else pass_cnt++;
    chk_cnt++; if (a0 !== {tag_of(7, 4), llc_set_t'(7)}) $display("FAIL bp_addr: got %h want %h", a0, {tag_of(7, 4), llc_set_t'(7)}); else pass_cnt++;
    @(posedge clk); #1;
    wb_ready = 1'b1;
    wait_done(cyc, inv, wbv, last, prev_inv, got, bd);
    chk_cnt++; if (!got || sb.size() != 0) $display("FAIL bp_complete: got done %b left %0d want 1 0", got, sb.size()); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    bit acc, found;
    int d0;
    m_state[100][1] = 3'd4; m_dirty[100][1] = 1'b1;
    wb_ready = 1'b0;
    start_flush(acc);
    found = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin found = 1; break; end
    end
    chk_cnt++; if (!found || mem_set !== llc_set_t'(100)) $display("FAIL abort_scan_set: got %0d (found %b) want 100", mem_set, found); else pass_cnt++;
    #3 rst = 1'b0;
    #1;
    chk_cnt++; if (wb_valid !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_rst_flush !== '0) $display("FAIL abort_outputs: got wb %b rd %b wr %h want 0 0 0", wb_valid, mem_rd_en, mem_wr_rst_flush); else pass_cnt++;
    chk_cnt++; if (mem_set !== '0 || busy !== 1'b1 || flush_req_ready !== 1'b0) $display("FAIL abort_state: got set %0d busy %b ready %b want 0 1 0", mem_set, busy, flush_req_ready); else pass_cnt++;
    sb.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_init();
    chk_cnt++; if (done_cnt != d0) $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); else pass_cnt++;
    chk_cnt++; if (m_state[100][1] != INVALID) $display("FAIL abort_reinit: got state %0d want 0", m_state[100][1]); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    flush_req_valid = 1'b0;
    wb_ready = 1'b0;
    test_reset();
    test_init();
    test_clean_flush();
    test_dirty_ways();
    test_backpressure();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
